// File: rtl/vout_fpdlink_enc_if.sv
// vout_fpdlink_enc_if: pixel-pair video in, 42-bit FPD-Link serializer word out.
interface vout_fpdlink_enc_if;
    logic        v_vsync;
    logic        v_hsync;
    logic        v_de;
    logic [47:0] v_pixel;
    logic        v_valid;
    logic [41:0] dout;
    logic        tx_active;
    modport master (output v_vsync, v_hsync, v_de, v_pixel, v_valid, input dout, tx_active);
    modport slave (input v_vsync, v_hsync, v_de, v_pixel, v_valid, output dout, tx_active);
endinterface

// File: rtl/vout_fpdlink_enc.sv
// vout_fpdlink_enc: dual-link FPD-Link I encoder, RGB888 pixel pairs to a 42-bit word, idle until vsync.
// Define VOUT_FPDLINK_DITHER_EN for 2x2 ordered temporal dither; otherwise colour is truncated.
module vout_fpdlink_enc (
    input logic               clk,
    input logic               rst,
    vout_fpdlink_enc_if.slave vif
);
    typedef enum logic {S_WAIT, S_RUN} state_t;
    state_t      state;
    logic        s1_vsync, s1_hsync, s1_de, s1_valid, s1_vsync_q;
    logic [47:0] s1_pixel;
    logic        vs_rise, live;
    logic [5:0]  c6 [6];
    logic [41:0] word;
    assign vs_rise = s1_vsync & ~s1_vsync_q;
    assign live = s1_valid & ((state == S_RUN) | vs_rise);
`ifdef VOUT_FPDLINK_DITHER_EN
    logic [1:0] frame_cnt;
    logic       line_par, s1_de_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            line_par <= 1'b0;
            s1_de_q <= 1'b0;
        end else begin
            s1_de_q <= s1_de;
            frame_cnt <= frame_cnt + {1'b0, vs_rise};
            line_par <= vs_rise ? 1'b0 : (s1_de_q & ~s1_de) ? ~line_par : line_par;
        end
    end
`endif
    // channel i: 0..2 = R/G/B even, 3..5 = R/G/B odd; sum kept at 9 bits so 255+3 saturates
    for (genvar i = 0; i < 6; i++) begin : g_red
        logic [1:0] t;
        logic [6:0] sh;
`ifdef VOUT_FPDLINK_DITHER_EN
        logic [1:0] idx;
        assign idx = {line_par, 1'(i / 3)} + frame_cnt;
        assign t = (idx == 2'd0) ? 2'd0 : (idx == 2'd1) ? 2'd2 : (idx == 2'd2) ? 2'd3 : 2'd1;
`else
        assign t = 2'd0;
`endif
        assign sh = 7'(({1'b0, s1_pixel[47 - 8*i -: 8]} + {7'd0, t}) >> 2);
        assign c6[i] = sh[6] ? 6'h3F : sh[5:0];
    end
    assign word = {c6[4][0], c6[3], c6[5][1:0], c6[4][5:1], s1_de, s1_vsync, s1_hsync, c6[5][5:2],
                   c6[1][0], c6[0], c6[2][1:0], c6[1][5:1], s1_de, s1_vsync, s1_hsync, c6[2][5:2]};
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vsync <= 1'b0;
            s1_hsync <= 1'b0;
            s1_de <= 1'b0;
            s1_valid <= 1'b0;
            s1_vsync_q <= 1'b0;
            s1_pixel <= '0;
            state <= S_WAIT;
            vif.dout <= '0;
            vif.tx_active <= 1'b0;
        end else begin
            s1_vsync <= vif.v_vsync;
            s1_hsync <= vif.v_hsync;
            s1_de <= vif.v_de;
            s1_valid <= vif.v_valid;
            s1_vsync_q <= s1_vsync;
            s1_pixel <= vif.v_pixel;
            state <= !s1_valid ? S_WAIT : vs_rise ? S_RUN : state;
            vif.dout <= live ? word : '0;
            vif.tx_active <= live;
        end
    end
endmodule

// File: tb/tb_vout_fpdlink_enc.sv
// tb_vout_fpdlink_enc: table vectors plus scoreboard-checked sequences for the FPD-Link encoder.
module tb_vout_fpdlink_enc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    vout_fpdlink_enc_if vif();
    vout_fpdlink_enc dut (.clk(clk), .rst(rst), .vif(vif));
    always #5 clk = ~clk;

    typedef struct packed {logic [41:0] d; logic tx;} exp_t;
    typedef struct {logic [47:0] pix; logic de, vs, hs; logic [41:0] exp;} vec_t;
    exp_t  q[$];
    vec_t  tbl[5];
    int    n_vec = 0, n_err = 0;
    string phase = "init";
    logic  m_pvs = 1'b0, m_run = 1'b0;
`ifdef VOUT_FPDLINK_DITHER_EN
    logic [1:0] fc = 2'd0;
    logic       lp = 1'b0, m_pde = 1'b0;
`endif

    function automatic logic [5:0] red(input logic [7:0] c, input logic x);
        int t, s;
`ifdef VOUT_FPDLINK_DITHER_EN
        case ((int'({lp, x}) + int'(fc)) % 4)
            0: t = 0;
            1: t = 2;
            2: t = 3;
            default: t = 1;
        endcase
`else
        t = int'(x) * 0;
`endif
        s = (int'(c) + t) >> 2;
        return s > 63 ? 6'd63 : 6'(s);
    endfunction

    function automatic logic [41:0] pack(input logic [47:0] p, input logic de, vs, hs);
        logic [41:0] w;
        logic [5:0] re, ge, be, ro, go, bo;
        re = red(p[47:40], 1'b0); ge = red(p[39:32], 1'b0); be = red(p[31:24], 1'b0);
        ro = red(p[23:16], 1'b1); go = red(p[15:8], 1'b1); bo = red(p[7:0], 1'b1);
        w = '0;
        w[40:35] = ro; w[32:28] = go[5:1]; w[41] = go[0]; w[24:21] = bo[5:2]; w[34:33] = bo[1:0];
        w[19:14] = re; w[11:7] = ge[5:1]; w[20] = ge[0]; w[3:0] = be[5:2]; w[13:12] = be[1:0];
        w[27] = de; w[26] = vs; w[25] = hs; w[6] = de; w[5] = vs; w[4] = hs;
        return w;
    endfunction

    task automatic cmp(input string name, input exp_t e);
        n_vec++;
        if (vif.dout !== e.d || vif.tx_active !== e.tx) begin
            n_err++;
            $display("FAIL %s: got dout=%h tx_active=%b, want dout=%h tx_active=%b",
                     name, vif.dout, vif.tx_active, e.d, e.tx);
        end
    endtask

    task automatic step(input logic [47:0] pix, input logic de, vs, hs, valid,
                        input logic tbl_en, input logic [41:0] tbl_exp);
        logic rise;
        exp_t e;
        vif.v_pixel = pix; vif.v_de = de; vif.v_vsync = vs; vif.v_hsync = hs; vif.v_valid = valid;
        rise = vs & ~m_pvs;
        m_pvs = vs;
        m_run = valid & (m_run | rise);
        e.tx = m_run;
        e.d = !m_run ? '0 : tbl_en ? tbl_exp : pack(pix, de, vs, hs);
`ifdef VOUT_FPDLINK_DITHER_EN
        lp = rise ? 1'b0 : (m_pde & ~de) ? ~lp : lp;
        fc = fc + (rise ? 2'd1 : 2'd0);
        m_pde = de;
`endif
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() >= 2) cmp(phase, q.pop_front());
    endtask

    task automatic go(input logic [47:0] pix, input logic de, vs, hs, valid);
        step(pix, de, vs, hs, valid, 1'b0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vif.v_pixel = '0; vif.v_de = 1'b0; vif.v_vsync = 1'b0; vif.v_hsync = 1'b0; vif.v_valid = 1'b0;
        @(posedge clk);
        #1;
        cmp("reset", '0);
        rst = 1'b0;
        q.delete();
        q.push_back('0);
        m_pvs = 1'b0; m_run = 1'b0;
`ifdef VOUT_FPDLINK_DITHER_EN
        fc = 2'd0; lp = 1'b0; m_pde = 1'b0;
`endif
    endtask

    task automatic line(input int n, input logic valid);
        for (int i = 0; i < n; i++) go({$urandom, $urandom}, 1'b1, 1'b0, 1'b0, valid);
        go('0, 1'b0, 1'b0, 1'b1, valid);
        go('0, 1'b0, 1'b0, 1'b0, valid);
    endtask

    initial begin
        tbl[0] = '{48'hFC0000_0000FC, 1'b1, 1'b0, 1'b0, 42'h609EFC040};
        tbl[1] = '{48'hFFFFFF_FFFFFF, 1'b1, 1'b0, 1'b1, 42'h3FFFBFFFFDF};
        tbl[2] = '{48'h0, 1'b0, 1'b0, 1'b1, 42'h2000010};
        tbl[3] = '{48'h0, 1'b1, 1'b0, 1'b0, 42'h8000040};
        tbl[4] = '{48'h0, 1'b0, 1'b1, 1'b0, 42'h4000020};
        do_reset();
        phase = "idle_no_vsync";
        for (int i = 0; i < 100; i++) go({$urandom, $urandom}, (i % 4) < 2, 1'b0, (i % 10) == 0, 1'b1);
        phase = "vsync_start";
        go('0, 1'b0, 1'b1, 1'b0, 1'b1);
        go('0, 1'b0, 1'b1, 1'b0, 1'b1);
        go('0, 1'b0, 1'b0, 1'b0, 1'b1);
        phase = "table";
        for (int i = 0; i < 5; i++) step(tbl[i].pix, tbl[i].de, tbl[i].vs, tbl[i].hs, 1'b1, 1'b1, tbl[i].exp);
        go('0, 1'b0, 1'b0, 1'b0, 1'b1);
        phase = "bit_walk";
        for (int p = 0; p < 48; p++) begin
            logic [47:0] one;
            one = 48'd1;
            if ((p % 8) >= 2) go(one << p, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        phase = "frames";
        for (int f = 0; f < 4; f++) begin
            go('0, 1'b0, 1'b1, 1'b0, 1'b1);
            go('0, 1'b0, 1'b1, 1'b0, 1'b1);
            go('0, 1'b0, 1'b0, 1'b0, 1'b1);
            for (int l = 0; l < 3; l++) begin
                go({6{8'hFF}}, 1'b1, 1'b0, 1'b0, 1'b1);
                go({6{8'h01}}, 1'b1, 1'b0, 1'b0, 1'b1);
                go({8'hFE, 8'h02, 8'hFD, 8'h03, 8'hFC, 8'h7F}, 1'b1, 1'b0, 1'b0, 1'b1);
                line(3, 1'b1);
            end
        end
        phase = "source_loss";
        go({$urandom, $urandom}, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) go({$urandom, $urandom}, 1'b1, 1'b0, 1'b0, 1'b0);
        go('0, 1'b0, 1'b1, 1'b0, 1'b0);
        go('0, 1'b0, 1'b1, 1'b0, 1'b1);
        go('0, 1'b0, 1'b0, 1'b0, 1'b1);
        line(6, 1'b1);
        phase = "restart_after_loss";
        go('0, 1'b0, 1'b1, 1'b0, 1'b1);
        go('0, 1'b0, 1'b0, 1'b0, 1'b1);
        line(6, 1'b1);
        phase = "reset_mid_frame";
        go({$urandom, $urandom}, 1'b1, 1'b0, 1'b0, 1'b1);
        do_reset();
        line(6, 1'b1);
        go('0, 1'b0, 1'b1, 1'b0, 1'b1);
        go('0, 1'b0, 1'b0, 1'b0, 1'b1);
        line(6, 1'b1);
        go('0, 1'b0, 1'b0, 1'b0, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
